// File: rtl/store_buffer.sv
// store_buffer: write-through store FIFO between dm_cache and data_mem.
// Stores are queued in a circular buffer and drained in order over a
// valid/ready handshake. Read misses are checked against queued stores.
// Optional feature macro: STORE_BUF_FORWARD_EN. When defined, a read that
// hits a queued word store is serviced by forwarding instead of stalling.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [2:0]                 wr_mode,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic [2:0]                 mem_mode,
  input  logic                       rd_req,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_stall,
  output logic                       rd_fwd_valid,
  output logic [DATA_WIDTH-1:0]      rd_fwd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [2:0] DATA_ADDR_MODE_W = 3'b010;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [2:0]            mode_q [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             empty_w;
  logic             full_w;
  logic             enq;
  logic             deq;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty_w  = (head_q == tail_q);
  assign full_w   = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // A full buffer refuses stores even when the head drains in the same cycle.
  assign enq = wr_valid && !full_w;
  assign deq = !empty_w && mem_ready;

  assign wr_ready  = !full_w;
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = tail_q - head_q;
  assign mem_valid = !empty_w;
  assign mem_addr  = addr_q[head_idx];
  assign mem_data  = data_q[head_idx];
  assign mem_mode  = mode_q[head_idx];

  // Next-state for pointers and per-entry valid flags.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    if (enq) begin
      tail_d          = tail_q + PTR_W'(1);
      vld_d[tail_idx] = 1'b1;
    end
    if (deq) begin
      head_d          = head_q + PTR_W'(1);
      vld_d[head_idx] = 1'b0;
    end
  end

  // Control state; reset discards every pending entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  // Entry payload is written at the tail; no reset since valids gate its use.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_idx] <= wr_addr;
      data_q[tail_idx] <= wr_data;
      mode_q[tail_idx] <= wr_mode;
    end
  end

  logic                  hit;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [2:0]            sel_mode;

  // Word-address match over registered entries, scanning head to tail so the
  // youngest match wins; a store enqueuing this cycle is not yet visible.
  always_comb begin
    logic [IDX_W-1:0] idx;
    hit      = 1'b0;
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + IDX_W'(i);
      if (vld_q[idx] && (addr_q[idx][ADDR_WIDTH-1:2] == rd_addr[ADDR_WIDTH-1:2])) begin
        hit      = 1'b1;
        sel_data = data_q[idx];
        sel_mode = mode_q[idx];
      end
    end
  end

  logic unused_rd_lsb;
  assign unused_rd_lsb = ^rd_addr[1:0];

`ifdef STORE_BUF_FORWARD_EN
  assign rd_fwd_valid = rd_req && hit && (sel_mode == DATA_ADDR_MODE_W);
  assign rd_fwd_data  = rd_fwd_valid ? sel_data : '0;
  assign rd_stall     = rd_req && hit && (sel_mode != DATA_ADDR_MODE_W);
`else
  logic unused_sel;
  assign unused_sel   = ^{sel_data, sel_mode};
  assign rd_fwd_valid = 1'b0;
  assign rd_fwd_data  = '0;
  assign rd_stall     = rd_req && hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table-driven vectors plus hand-written
// sequences, with a drain-order scoreboard fed from driven stores.
module tb_store_buffer;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [2:0] MW = 3'b010;
  localparam logic [2:0] MB = 3'b000;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    wr_mode;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [2:0]    mem_mode;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_stall;
  logic          rd_fwd_valid;
  logic [DW-1:0] rd_fwd_data;
  logic [$clog2(DEPTH):0] count;
  logic          empty;
  logic          full;

  store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mode(wr_mode),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mode(mem_mode),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_stall(rd_stall),
    .rd_fwd_valid(rd_fwd_valid), .rd_fwd_data(rd_fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    m;
  } ent_t;

  ent_t sb[$];
  ent_t ent;

  // Scoreboard: pop/compare on each handshake, push each accepted store.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain_unexpected actual=%0h required=none", mem_addr);
        end else begin
          ent = sb.pop_front();
          chk("drain_addr", {32'd0, mem_addr}, {32'd0, ent.a});
          chk("drain_data", {32'd0, mem_data}, {32'd0, ent.d});
          chk("drain_mode", {61'd0, mem_mode}, {61'd0, ent.m});
        end
      end
      if (wr_valid && wr_ready) sb.push_back('{wr_addr, wr_data, wr_mode});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);
    mem_ready = 1'b0;
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          mr;
    logic          rq;
    logic [AW-1:0] ra;
    int            cnt;
    logic          full;
    logic          empty;
    logic          wrr;
    logic          mv;
    logic          hit;
  } vec_t;

  vec_t vec [14];

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = MW;
    mem_ready = 1'b0; rd_req = 1'b0; rd_addr = '0;

    vec[0]  = '{1'b1, 32'h10, 32'hA1, 1'b0, 1'b0, 32'h0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 32'h14, 32'hA2, 1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 32'h18, 32'hA3, 1'b0, 1'b0, 32'h0,  2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 32'h1C, 32'hA4, 1'b0, 1'b0, 32'h0,  3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 32'h20, 32'hA5, 1'b0, 1'b0, 32'h0,  4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 32'h20, 32'hA5, 1'b1, 1'b0, 32'h0,  4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 32'h20, 32'hA5, 1'b1, 1'b0, 32'h0,  3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'h1A, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'h24, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'h14, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[10] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h1C, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[11] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h18, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[12] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h20, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[13] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'h20, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state, probed with a read request present.
    tick(); tick();
    rd_req = 1'b1;
    #1;
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_stall", {63'd0, rd_stall}, 64'd0);
    chk("rst_fwd_valid", {63'd0, rd_fwd_valid}, 64'd0);
    chk("rst_fwd_data", {32'd0, rd_fwd_data}, 64'd0);
    rd_req = 1'b0;
    rst_n  = 1'b1;
    tick();

    // Single word store with memory ready: one-cycle latency, then empty.
    wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEADBEEF; wr_mode = MW; mem_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t1_mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("t1_mem_addr", {32'd0, mem_addr}, 64'h100);
    chk("t1_mem_data", {32'd0, mem_data}, 64'hDEADBEEF);
    chk("t1_count", {61'd0, count}, 64'd1);
    tick();
    chk("t1_empty", {63'd0, empty}, 64'd1);
    chk("t1_count0", {61'd0, count}, 64'd0);
    mem_ready = 1'b0;

    // Table: fill to full, back-pressure, release, and hazard lookups.
    for (int k = 0; k < 14; k++) begin
      wr_valid = vec[k].wv; wr_addr = vec[k].wa; wr_data = vec[k].wd; wr_mode = MW;
      mem_ready = vec[k].mr; rd_req = vec[k].rq; rd_addr = vec[k].ra;
      @(negedge clk);
      chk($sformatf("v%0d_count", k), {61'd0, count}, 64'(vec[k].cnt));
      chk($sformatf("v%0d_full", k), {63'd0, full}, {63'd0, vec[k].full});
      chk($sformatf("v%0d_empty", k), {63'd0, empty}, {63'd0, vec[k].empty});
      chk($sformatf("v%0d_wr_ready", k), {63'd0, wr_ready}, {63'd0, vec[k].wrr});
      chk($sformatf("v%0d_mem_valid", k), {63'd0, mem_valid}, {63'd0, vec[k].mv});
`ifdef STORE_BUF_FORWARD_EN
      chk($sformatf("v%0d_stall", k), {63'd0, rd_stall}, 64'd0);
      chk($sformatf("v%0d_fwd", k), {63'd0, rd_fwd_valid}, {63'd0, vec[k].hit});
`else
      chk($sformatf("v%0d_stall", k), {63'd0, rd_stall}, {63'd0, vec[k].hit});
      chk($sformatf("v%0d_fwd", k), {63'd0, rd_fwd_valid}, 64'd0);
`endif
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0; rd_req = 1'b0; mem_ready = 1'b0;

    // Continuous enqueue+dequeue across several pointer wraps.
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = 32'h500 + 32'(4 * i); wr_data = 32'hC000 + 32'(i); wr_mode = MW;
      tick();
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      wr_valid = 1'b1; wr_addr = 32'h400 + 32'(4 * i); wr_data = 32'hB000 + 32'(i);
      wr_mode = 3'(i);
      @(negedge clk);
      chk($sformatf("t3_count%0d", i), {61'd0, count}, 64'd2);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    drain();

    // Hazard on a queued word store with memory stalled.
    wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h55; wr_mode = MW;
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 32'h202;
    #1;
`ifdef STORE_BUF_FORWARD_EN
    chk("t4_stall_202", {63'd0, rd_stall}, 64'd0);
    chk("t4_fwd_data_202", {32'd0, rd_fwd_data}, 64'h55);
`else
    chk("t4_stall_202", {63'd0, rd_stall}, 64'd1);
    chk("t4_fwd_data_202", {32'd0, rd_fwd_data}, 64'd0);
`endif
    rd_addr = 32'h204;
    #1;
    chk("t4_stall_204", {63'd0, rd_stall}, 64'd0);
    rd_req = 1'b0;
    #1;
    drain();

`ifdef STORE_BUF_FORWARD_EN
    // Forwarding picks the youngest word store; a younger byte store stalls.
    wr_valid = 1'b1; wr_addr = 32'h300; wr_data = 32'h11; wr_mode = MW;
    tick();
    wr_data = 32'h22;
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 32'h300;
    #1;
    chk("t5_fwd_valid", {63'd0, rd_fwd_valid}, 64'd1);
    chk("t5_fwd_data", {32'd0, rd_fwd_data}, 64'h22);
    chk("t5_stall", {63'd0, rd_stall}, 64'd0);
    wr_valid = 1'b1; wr_addr = 32'h301; wr_data = 32'h33; wr_mode = MB;
    #1;
    chk("t5_enq_not_seen", {63'd0, rd_fwd_valid}, 64'd1);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("t5_byte_stall", {63'd0, rd_stall}, 64'd1);
    chk("t5_byte_fwd", {63'd0, rd_fwd_valid}, 64'd0);
    rd_req = 1'b0;
    drain();
`endif

    // Asynchronous reset with entries pending discards them immediately.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 32'h600 + 32'(4 * i); wr_data = 32'hE0 + 32'(i); wr_mode = MW;
      tick();
    end
    wr_valid = 1'b0;
    chk("t6_pre_mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("t6_pre_count", {61'd0, count}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("t6_empty", {63'd0, empty}, 64'd1);
    sb.delete();
    tick();
    rst_n = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_stale%0d", i), {63'd0, mem_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
